pulse_period_meter: RTL and testbench

PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

---
 rtl/pulse_period_meter.sv | 113 +++++++++++
 tb/tb_pulse_period_meter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Measures the interval, in enabled clock edges, between successive events on i_pulse.
// Reports the last period with done/valid/lock status and a sticky overflow flag.
module pulse_period_meter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_meas_enbl,
  input  logic             i_pulse,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_period,
  output logic             o_done,
  output logic             o_valid,
  output logic             o_lock,
  output logic             o_overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_LAST = CNT_MAX - ONE;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] period_nxt;
  logic             done_nxt, valid_nxt, lock_nxt, ovf_nxt;
  logic [WIDTH-1:0] cnt_inc;

  // cnt never exceeds CNT_LAST, so the increment cannot wrap
  assign cnt_inc = cnt + ONE;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      o_period   <= '0;
      o_done     <= 1'b0;
      o_valid    <= 1'b0;
      o_lock     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      o_period   <= period_nxt;
      o_done     <= done_nxt;
      o_valid    <= valid_nxt;
      o_lock     <= lock_nxt;
      o_overflow <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    period_nxt = o_period;
    done_nxt   = 1'b0;
    valid_nxt  = o_valid;
    lock_nxt   = o_lock;
    ovf_nxt    = o_overflow;

    if (i_clear) begin
      state_nxt  = i_meas_enbl ? ARMED : IDLE;
      cnt_nxt    = '0;
      period_nxt = '0;
      valid_nxt  = 1'b0;
      lock_nxt   = 1'b0;
      ovf_nxt    = 1'b0;
    end else if (!i_meas_enbl) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      lock_nxt  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_nxt   = '0;
          state_nxt = ARMED;
        end
        ARMED: begin
          cnt_nxt = '0;
          if (i_pulse) state_nxt = MEASURE;
        end
        MEASURE: begin
          if (i_pulse) begin
            period_nxt = cnt_inc;
            done_nxt   = 1'b1;
            valid_nxt  = 1'b1;
            lock_nxt   = o_valid && (cnt_inc == o_period);
            cnt_nxt    = '0;
          end else if (cnt == CNT_LAST) begin
            // interval too long to represent: drop the result and re-arm
            ovf_nxt   = 1'b1;
            valid_nxt = 1'b0;
            lock_nxt  = 1'b0;
            cnt_nxt   = '0;
            state_nxt = ARMED;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: stimulus pushes expected captures,
// a negedge monitor pops and checks them whenever o_done strobes.
module tb_pulse_period_meter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             i_rst_n;
  logic             i_meas_enbl;
  logic             i_pulse;
  logic             i_clear;
  logic [WIDTH-1:0] o_period;
  logic             o_done;
  logic             o_valid;
  logic             o_lock;
  logic             o_overflow;

  typedef struct packed {
    logic [WIDTH-1:0] period;
    logic             lock;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  pulse_period_meter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_meas_enbl(i_meas_enbl),
    .i_pulse    (i_pulse),
    .i_clear    (i_clear),
    .o_period   (o_period),
    .o_done     (o_done),
    .o_valid    (o_valid),
    .o_lock     (o_lock),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input logic p);
    i_pulse = p;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic expect_cap(input int period, input logic lock, input logic ovf);
    exp_t e;
    e.period = WIDTH'(period);
    e.lock   = lock;
    e.ovf    = ovf;
    exp_q.push_back(e);
  endtask

  task automatic chk_all(input string name, input int period, input logic valid,
                         input logic lock, input logic ovf, input logic done);
    chk({name, ".period"}, int'(o_period), period);
    chk({name, ".valid"}, int'(o_valid), int'(valid));
    chk({name, ".lock"}, int'(o_lock), int'(lock));
    chk({name, ".ovf"}, int'(o_overflow), int'(ovf));
    chk({name, ".done"}, int'(o_done), int'(done));
  endtask

  // monitor: every capture strobe must match the oldest pending expectation
  always @(negedge clk) begin
    if (i_rst_n && o_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cap.period", int'(o_period), int'(e.period));
        chk("cap.valid", int'(o_valid), 1);
        chk("cap.lock", int'(o_lock), int'(e.lock));
        chk("cap.ovf", int'(o_overflow), int'(e.ovf));
      end
    end
  end

  initial begin
    i_rst_n     = 1'b0;
    i_meas_enbl = 1'b0;
    i_pulse     = 1'b0;
    i_clear     = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0);
    i_rst_n = 1'b1;

    // period 5, three events; lock after the second capture of 5
    i_meas_enbl = 1'b1;
    tick(1'b0);
    tick(1'b1);
    quiet(4); expect_cap(5, 0, 0); tick(1'b1);
    quiet(4); expect_cap(5, 1, 0); tick(1'b1);
    chk("p5.lock", int'(o_lock), 1);
    chk("p5.period", int'(o_period), 5);
    // then period 7 drops lock
    quiet(6); expect_cap(7, 0, 0); tick(1'b1);
    chk("p7.lock", int'(o_lock), 0);
    tick(1'b0);
    chk("done_one_cycle", int'(o_done), 0);

    // clear, then pulse held high: three captures of 1
    i_clear = 1'b1; tick(1'b0); i_clear = 1'b0;
    chk_all("clear1", 0, 0, 0, 0, 0);
    tick(1'b1);
    expect_cap(1, 0, 0); tick(1'b1);
    expect_cap(1, 1, 0); tick(1'b1);
    expect_cap(1, 1, 0); tick(1'b1);
    tick(1'b0);

    // largest representable period, then overflow
    i_clear = 1'b1; tick(1'b0); i_clear = 1'b0;
    tick(1'b1);
    quiet(14); expect_cap(15, 0, 0); tick(1'b1);
    chk("max.ovf", int'(o_overflow), 0);
    quiet(15);
    chk_all("ovf", 15, 0, 0, 1, 0);
    // state is ARMED: next event only arms, then captures with sticky overflow
    tick(1'b1);
    quiet(2); expect_cap(3, 0, 1); tick(1'b1);

    // clear coincident with an event
    quiet(2);
    i_clear = 1'b1; tick(1'b1); i_clear = 1'b0;
    chk_all("clear_evt", 0, 0, 0, 0, 0);
    tick(1'b1);
    quiet(2); expect_cap(3, 0, 0); tick(1'b1);

    // disable mid-interval: results hold, pulses ignored, re-enable only arms
    tick(1'b0);
    i_meas_enbl = 1'b0;
    tick(1'b0);
    chk_all("disable", 3, 1, 0, 0, 0);
    tick(1'b1);
    tick(1'b1);
    chk("disable.period", int'(o_period), 3);
    i_meas_enbl = 1'b1;
    tick(1'b1);
    tick(1'b1);
    quiet(3); expect_cap(4, 0, 0); tick(1'b1);

    // asynchronous reset while o_done is high
    quiet(4); expect_cap(5, 0, 0); tick(1'b1);
    #2 i_rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    // restarts from IDLE: one edge to ARMED, one event to arm, then measure
    tick(1'b1);
    tick(1'b1);
    quiet(1); expect_cap(2, 0, 0); tick(1'b1);
    quiet(3);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
